// File: rtl/riscv_instr_mem_responder_if.sv
// Purpose : instruction-fetch request/grant/rvalid bus between the core's prefetch buffer and its responder.
// Latency : n/a (wires only); grant is combinational, rvalid follows the responder's fixed latency.
// Backpr. : the responder withholds instr_gnt_o; the initiator keeps instr_req_i high until granted.
// Ports   : master drives req/addr and samples gnt/rvalid/rdata; slave is the mirror image.
interface riscv_instr_mem_responder_if;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o
  );

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o
  );
endinterface

// File: rtl/riscv_instr_mem_responder.sv
// Purpose : responder for the instruction-fetch bus; reads a synchronous word RAM and returns data in grant order.
// Latency : rvalid exactly RDATA_LATENCY cycles after grant; grant itself is combinational.
// Backpr. : grant suppressed by gnt_stall_i, by reset, or when MAX_OUTSTANDING are in flight and none retires.
// Ports   : clk/rst (sync, active-high); bus = fetch slave; gnt_stall_i = external stall;
//           mem_en_o/mem_addr_o/mem_rdata_i = RAM read port (data one cycle after enable);
//           outstanding_o = current in-flight count.
module riscv_instr_mem_responder #(
  parameter int ADDR_WIDTH      = 12,
  parameter int RDATA_LATENCY   = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  riscv_instr_mem_responder_if.slave           bus,
  input  logic                                 gnt_stall_i,
  output logic                                 mem_en_o,
  output logic [ADDR_WIDTH-1:0]                mem_addr_o,
  input  logic [31:0]                          mem_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  localparam int            CW    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  logic [CW-1:0]            cnt_q;
  logic [RDATA_LATENCY-1:0] vld_q;
  logic                     retire;
  logic                     gnt;

  // A retiring response frees its slot in the same cycle, so a full
  // responder can still grant and keep the pipeline busy.
  assign retire = vld_q[RDATA_LATENCY-1];
  assign gnt    = bus.instr_req_i & ~gnt_stall_i & ~rst & ((cnt_q < MAX_C) | retire);

  assign bus.instr_gnt_o    = gnt;
  assign bus.instr_rvalid_o = retire;
  assign mem_en_o           = gnt;
  assign mem_addr_o         = bus.instr_addr_i[ADDR_WIDTH+1:2];
  assign outstanding_o      = cnt_q;

  // Byte-offset and above-range address bits are intentionally ignored
  // (addresses wrap modulo the RAM size).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.instr_addr_i[31:ADDR_WIDTH+2], bus.instr_addr_i[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (gnt && !retire) begin
      cnt_q <= cnt_q + CW'(1);
    end else if (!gnt && retire) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // Valid shift register: bit 0 is "RAM output valid", the top bit is rvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= RDATA_LATENCY'({vld_q, gnt});
    end
  end

  generate
    if (RDATA_LATENCY == 1) begin : g_lat1
      // RAM output is the final stage; a hold register keeps the last
      // delivered word visible while rvalid is low.
      logic [31:0] hold_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          hold_q <= '0;
        end else if (vld_q[0]) begin
          hold_q <= mem_rdata_i;
        end
      end

      assign bus.instr_rdata_o = vld_q[0] ? mem_rdata_i : hold_q;
    end else begin : g_latn
      // dat_q[i] holds the word whose valid is vld_q[i+1]; each stage only
      // loads when its predecessor is valid, so the last stage naturally
      // holds the last delivered word.
      logic [31:0] dat_q [RDATA_LATENCY-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < RDATA_LATENCY - 1; i++) begin
            dat_q[i] <= '0;
          end
        end else begin
          if (vld_q[0]) begin
            dat_q[0] <= mem_rdata_i;
          end
          for (int i = 1; i < RDATA_LATENCY - 1; i++) begin
            if (vld_q[i]) begin
              dat_q[i] <= dat_q[i-1];
            end
          end
        end
      end

      assign bus.instr_rdata_o = dat_q[RDATA_LATENCY-2];
    end
  endgenerate

  a_cnt_max : assert property (@(posedge clk) disable iff (rst) cnt_q <= MAX_C);
  a_cnt_underflow : assert property (@(posedge clk) disable iff (rst) !(retire && cnt_q == '0));

endmodule

// File: tb/tb_riscv_instr_mem_responder.sv
// Bench for riscv_instr_mem_responder: four latency/limit configurations side by side,
// each with its own RAM model, directed prologue, random traffic and a queue-based
// reference model of in-flight fetches checked by a negedge monitor.
module tb_riscv_instr_mem_responder;

  localparam int NCFG  = 4;
  localparam int NRAND = 2000;
  // Per-config latency / outstanding limit, one nibble per config (config 0 in the low nibble).
  localparam logic [15:0] LAT_TAB = {4'd4, 4'd3, 4'd2, 4'd1};
  localparam logic [15:0] MAX_TAB = {4'd5, 4'd1, 4'd2, 4'd2};

  bit clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void check(int k, string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL cfg%0d %s: got %h want %h", k, name, act, want);
    end
  endfunction

  for (genvar k = 0; k < NCFG; k++) begin : g_cfg
    localparam int L  = int'(LAT_TAB[4*k +: 4]);
    localparam int M  = int'(MAX_TAB[4*k +: 4]);
    localparam int CW = $clog2(M + 1);

    typedef struct {
      int          due;
      logic [31:0] dat;
    } exp_t;

    logic          rst;
    logic          stall;
    logic          mem_en;
    logic [11:0]   mem_addr;
    logic [31:0]   mem_rdata;
    logic [CW-1:0] outst;
    logic [31:0]   mem [4096];
    exp_t          q[$];
    logic [31:0]   last_dat = '0;
    int            cyc = 0;

    riscv_instr_mem_responder_if bus ();

    riscv_instr_mem_responder #(
      .ADDR_WIDTH      (12),
      .RDATA_LATENCY   (L),
      .MAX_OUTSTANDING (M)
    ) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .gnt_stall_i   (stall),
      .mem_en_o      (mem_en),
      .mem_addr_o    (mem_addr),
      .mem_rdata_i   (mem_rdata),
      .outstanding_o (outst)
    );

    // Synchronous RAM: data one cycle after the enable.
    always @(posedge clk) begin
      if (mem_en) mem_rdata <= mem[mem_addr];
    end

    // Reference: a queue of granted fetches, each due exactly L cycles after
    // its grant; a grant is legal while fewer than M are in flight or one is
    // being delivered this cycle.
    always @(negedge clk) begin
      bit   due;
      bit   exp_gnt;
      exp_t e;
      cyc++;
      if (rst) begin
        check(k, "gnt_in_rst", 32'(bus.instr_gnt_o), 32'd0);
        check(k, "mem_en_in_rst", 32'(mem_en), 32'd0);
        q.delete();
        last_dat = '0;
      end else begin
        due     = (q.size() > 0) && (q[0].due == cyc);
        exp_gnt = bus.instr_req_i && !stall && ((q.size() < M) || due);
        check(k, "gnt", 32'(bus.instr_gnt_o), 32'(exp_gnt));
        check(k, "mem_en", 32'(mem_en), 32'(exp_gnt));
        check(k, "mem_addr", 32'(mem_addr), 32'(bus.instr_addr_i[13:2]));
        check(k, "outstanding", 32'(outst), q.size());
        check(k, "rvalid", 32'(bus.instr_rvalid_o), 32'(due));
        if (due) begin
          check(k, "rdata", bus.instr_rdata_o, q[0].dat);
          last_dat = q[0].dat;
          void'(q.pop_front());
        end else begin
          check(k, "rdata_hold", bus.instr_rdata_o, last_dat);
        end
        if (exp_gnt) begin
          e.due = cyc + L;
          e.dat = mem[bus.instr_addr_i[13:2]];
          q.push_back(e);
        end
      end
    end

    initial begin
      int n;
      for (int i = 0; i < 4096; i++) mem[i] = $urandom;
      mem[5]  = 32'hDEAD_BEEF;
      mem[16] = 32'h1600_0016;
      rst = 1'b1;
      stall = 1'b0;
      bus.instr_req_i = 1'b0;
      bus.instr_addr_i = '0;
      repeat (3) @(posedge clk);

      // Single fetch of 0x14 in the first cycle out of reset.
      #1 rst = 1'b0;
      bus.instr_req_i = 1'b1;
      bus.instr_addr_i = 32'h14;
      @(posedge clk);
      #1 bus.instr_req_i = 1'b0;
      repeat (8) @(posedge clk);

      // Back-to-back stream: req held, address advances on each grant.
      #1 bus.instr_req_i = 1'b1;
      bus.instr_addr_i = 32'h0;
      n = 0;
      for (int c = 0; c < 60 && n < 8; c++) begin
        @(negedge clk);
        if (bus.instr_gnt_o) n++;
        @(posedge clk);
        #1 bus.instr_addr_i = 32'(n * 4);
      end
      bus.instr_req_i = 1'b0;
      repeat (8) @(posedge clk);

      // Stall with a redirect 0x10 -> 0x40 while waiting; latest address wins.
      #1 stall = 1'b1;
      bus.instr_req_i = 1'b1;
      bus.instr_addr_i = 32'h10;
      repeat (2) @(posedge clk);
      #1 bus.instr_addr_i = 32'h40;
      @(posedge clk);
      #1 stall = 1'b0;
      n = 0;
      for (int c = 0; c < 20 && n == 0; c++) begin
        @(negedge clk);
        if (bus.instr_gnt_o) n = 1;
        @(posedge clk);
        #1;
      end
      bus.instr_req_i = 1'b0;
      repeat (8) @(posedge clk);

      // Grant then reset the next cycle: the in-flight fetch must vanish.
      #1 bus.instr_req_i = 1'b1;
      bus.instr_addr_i = 32'h8;
      @(posedge clk);
      #1 bus.instr_req_i = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (8) @(posedge clk);

      // Random traffic: aborts, stalls, redirects, wrapping addresses, rare resets.
      for (int c = 0; c < NRAND; c++) begin
        #1;
        bus.instr_req_i = ($urandom_range(0, 3) != 0);
        stall = ($urandom_range(0, 3) == 0);
        rst = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 1) != 0) bus.instr_addr_i = $urandom;
        else bus.instr_addr_i = 32'($urandom_range(0, 63)) << 2;
        @(posedge clk);
      end

      // Drain: every granted fetch must have been delivered.
      #1 bus.instr_req_i = 1'b0;
      stall = 1'b0;
      rst = 1'b0;
      repeat (L + 4) @(posedge clk);
      #1 check(k, "drain_empty", q.size(), 32'd0);
    end
  end

  initial begin
    repeat (NRAND + 400) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
